// File: rtl/pulse_stretcher_out_if.sv
// Signal bundle between internal logic and the pulse stretcher output stage.
//   IN      : synchronous event level from internal logic; each 0->1 is one event
//   OUT     : registered stretched pulse toward the board pin
//   BUSY    : stretcher is emitting a pulse or enforcing the low gap
//   DROPPED : one-cycle flag when an event was discarded
// Modports: master = internal logic side, slave = pulse_stretcher_out.
interface pulse_stretcher_out_if;
    logic IN;
    logic OUT;
    logic BUSY;
    logic DROPPED;

    modport master (
        output IN,
        input  OUT,
        input  BUSY,
        input  DROPPED
    );

    modport slave (
        input  IN,
        output OUT,
        output BUSY,
        output DROPPED
    );
endinterface

// File: rtl/pulse_stretcher_out.sv
// Stretches rising edges of a synchronous internal level into fixed-width
// high pulses separated by a guaranteed low gap, with a one-deep event queue.
//   CLK   : clock, rising edge
//   RESET : asynchronous, active-high reset
//   bus   : slave side of pulse_stretcher_out_if (IN, OUT, BUSY, DROPPED)
// Parameters: HIGH_CYCLES (pulse width), GAP_CYCLES (minimum low gap),
// CNT_WIDTH (shared down-counter width); both cycle counts are 1..2^CNT_WIDTH.
module pulse_stretcher_out #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    pulse_stretcher_out_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] HIGH_LOAD = CNT_WIDTH'(HIGH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   cnt, cnt_next;
    logic                   pending, pending_next;
    logic                   dropped, dropped_next;
    logic                   in_d;
    logic                   evt;

    // in_d resets high so a level already high at reset release is not an event.
    assign evt = bus.IN & ~in_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            dropped <= 1'b0;
            in_d    <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pending <= pending_next;
            dropped <= dropped_next;
            in_d    <= bus.IN;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pending_next = pending;
        dropped_next = 1'b0;

        unique case (state)
            IDLE: begin
                if (evt) begin
                    state_next = HIGH;
                    cnt_next   = HIGH_LOAD;
                end
            end

            HIGH: begin
                if (cnt == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
                if (evt) begin
                    if (pending) dropped_next = 1'b1;
                    else         pending_next = 1'b1;
                end
            end

            GAP: begin
                if (cnt == '0) begin
                    // An event arriving on the consume edge either starts the
                    // next pulse itself (queue empty) or replaces the consumed
                    // entry (queue full); it is never dropped here.
                    if (pending || evt) begin
                        state_next   = HIGH;
                        cnt_next     = HIGH_LOAD;
                        pending_next = pending & evt;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                    if (evt) begin
                        if (pending) dropped_next = 1'b1;
                        else         pending_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Decoded from registered state only, so the pin never glitches.
    assign bus.OUT     = (state == HIGH);
    assign bus.BUSY    = (state != IDLE);
    assign bus.DROPPED = dropped;

endmodule
